// File: rtl/shift_monitor.sv
// ---------------------------------------------------------------------------
// shift_monitor
//
// Watches a 16-bit LED pattern that should show a single lit position walking
// one step per valid sample, and locks onto the walking direction once enough
// consistent steps have been seen.
//
// Parameters
//   LOCK_N  consecutive consistent steps required to lock (1..15)
//   ERR_W   width of the saturating error counter
//
// Ports
//   clk        single clock, rising-edge active
//   reset      asynchronous active-low reset
//   led_in     sampled LED pattern, bit i lit = position i
//   led_valid  led_in is sampled this cycle; when low all state holds
//   pos        index of the lit bit from the last valid one-hot sample
//   pos_valid  pos holds a decoded position
//   dir        locked direction, 1 = ascending, 0 = descending
//   locked     high while in LOCKED
//   err        one-cycle pulse on a protocol error
//   err_count  saturating count of err pulses
//   wrap       one-cycle pulse on a locked wrap step (15->0 up, 0->15 down)
// ---------------------------------------------------------------------------
module shift_monitor #(
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      led_in,
  input  logic             led_valid,
  output logic [3:0]       pos,
  output logic             pos_valid,
  output logic             dir,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_N);

  // Number of lit bits in a sample.
  function automatic logic [4:0] ones16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  // Index of the lit bit; only meaningful for a one-hot sample.
  function automatic logic [3:0] hot_index(input logic [15:0] v);
    logic [3:0] k;
    k = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) k = 4'(i);
    end
    return k;
  endfunction

  // Error counter increment that sticks at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  state_t     state;
  logic [3:0] prev;
  logic [3:0] cnt;
  logic       cand_up;

  logic [4:0] ones;
  logic       is_blank;
  logic       is_hot;
  logic       is_bad;
  logic [3:0] idx;
  logic [3:0] prev_up;
  logic [3:0] prev_dn;
  logic       step_up;
  logic       step_dn;
  logic       step_fwd;
  logic [3:0] cnt_inc;

  // Sample classification and step detection against the stored position.
  // prev_up/prev_dn are 4-bit, so the 15<->0 wrap is an ordinary step.
  always_comb begin
    ones     = ones16(led_in);
    is_blank = (ones == 5'd0);
    is_hot   = (ones == 5'd1);
    is_bad   = !is_blank && !is_hot;
    idx      = hot_index(led_in);
    prev_up  = prev + 4'd1;
    prev_dn  = prev - 4'd1;
    step_up  = is_hot && (idx == prev_up);
    step_dn  = is_hot && (idx == prev_dn);
    step_fwd = dir ? step_up : step_dn;
    cnt_inc  = cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      prev      <= '0;
      cnt       <= '0;
      cand_up   <= 1'b0;
      pos       <= '0;
      pos_valid <= 1'b0;
      dir       <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      wrap      <= 1'b0;
    end else begin
      // Pulses last exactly one cycle, including cycles with no sample.
      err  <= 1'b0;
      wrap <= 1'b0;

      if (led_valid) begin
        // pos always tracks the most recent one-hot sample, whatever the state.
        if (is_hot) pos <= idx;

        case (state)
          S_IDLE: begin
            if (is_hot) begin
              prev      <= idx;
              pos_valid <= 1'b1;
              cnt       <= '0;
              state     <= S_ACQ;
            end else if (is_bad) begin
              err       <= 1'b1;
              err_count <= sat_inc(err_count);
            end
          end

          S_ACQ: begin
            if (is_bad) begin
              err       <= 1'b1;
              err_count <= sat_inc(err_count);
              pos_valid <= 1'b0;
              cnt       <= '0;
              state     <= S_IDLE;
            end else if (is_hot) begin
              prev <= idx;
              // A zero count means no direction has been committed yet, so
              // either adjacent step starts a new run.
              if ((step_up || step_dn) && ((cnt == 4'd0) || (step_up == cand_up))) begin
                cand_up <= step_up;
                if (cnt_inc >= LOCK_C) begin
                  cnt    <= LOCK_C;
                  dir    <= step_up;
                  locked <= 1'b1;
                  state  <= S_LOCKED;
                end else begin
                  cnt <= cnt_inc;
                end
              end else begin
                cnt <= '0;
              end
            end
          end

          S_LOCKED: begin
            if (step_fwd) begin
              prev <= idx;
              wrap <= dir ? (idx == 4'd0) : (idx == 4'd15);
            end else begin
              err       <= 1'b1;
              err_count <= sat_inc(err_count);
              cnt       <= '0;
              locked    <= 1'b0;
              if (is_hot) begin
                prev  <= idx;
                state <= S_ACQ;
              end else begin
                pos_valid <= 1'b0;
                state     <= S_IDLE;
              end
            end
          end

          default: begin
            state     <= S_IDLE;
            locked    <= 1'b0;
            pos_valid <= 1'b0;
            cnt       <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_monitor.sv
// ---------------------------------------------------------------------------
// tb_shift_monitor
//
// Drives two shift_monitor instances (ERR_W=8 and ERR_W=2) with the same
// stimulus. A behavioural reference predicts the outputs for each sample; the
// prediction is queued when the sample is driven and compared one clock later.
// ---------------------------------------------------------------------------
module tb_shift_monitor;

  localparam int LOCK_N = 4;

  logic        clk;
  logic        reset;
  logic [15:0] led_in;
  logic        led_valid;

  logic [3:0]  pos;
  logic        pos_valid;
  logic        dir;
  logic        locked;
  logic        err;
  logic [7:0]  err_count;
  logic        wrap;

  logic [3:0]  pos2;
  logic        pos_valid2;
  logic        dir2;
  logic        locked2;
  logic        err2;
  logic [1:0]  err_count2;
  logic        wrap2;

  shift_monitor #(.LOCK_N(LOCK_N), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .led_in(led_in), .led_valid(led_valid),
    .pos(pos), .pos_valid(pos_valid), .dir(dir), .locked(locked),
    .err(err), .err_count(err_count), .wrap(wrap)
  );

  shift_monitor #(.LOCK_N(LOCK_N), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .led_in(led_in), .led_valid(led_valid),
    .pos(pos2), .pos_valid(pos_valid2), .dir(dir2), .locked(locked2),
    .err(err2), .err_count(err_count2), .wrap(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state (0 = IDLE, 1 = ACQ, 2 = LOCKED)
  int m_state, m_prev, m_cnt, m_pos, m_ec;
  bit m_cand, m_pv, m_dir, m_lock, m_err, m_wrap;

  typedef struct {
    int pos;
    bit pv, dir, lk, er, wr;
    int ec;
  } exp_t;

  exp_t sb[$];

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_cnt = 0; m_pos = 0; m_ec = 0;
    m_cand = 0; m_pv = 0; m_dir = 0; m_lock = 0; m_err = 0; m_wrap = 0;
  endtask

  task automatic bump_err();
    m_err = 1;
    if (m_ec < 255) m_ec++;
  endtask

  task automatic model(input logic [15:0] v, input bit vld);
    int n, k;
    bit up, dn;
    m_err  = 0;
    m_wrap = 0;
    if (!vld) return;
    n  = $countones(v);
    k  = (n == 1) ? $clog2(32'(v)) : 0;
    up = (n == 1) && (k == (m_prev + 1) % 16);
    dn = (n == 1) && (k == (m_prev + 15) % 16);
    if (n == 1) m_pos = k;
    case (m_state)
      0: begin
        if (n == 1) begin
          m_prev = k; m_pv = 1; m_cnt = 0; m_state = 1;
        end else if (n > 1) begin
          bump_err();
        end
      end
      1: begin
        if (n > 1) begin
          bump_err(); m_pv = 0; m_cnt = 0; m_state = 0;
        end else if (n == 1) begin
          if ((up || dn) && (m_cnt == 0 || up == m_cand)) begin
            m_cand = up;
            m_cnt++;
            if (m_cnt >= LOCK_N) begin
              m_cnt = LOCK_N; m_state = 2; m_lock = 1; m_dir = up;
            end
          end else begin
            m_cnt = 0;
          end
          m_prev = k;
        end
      end
      default: begin
        if ((m_dir && up) || (!m_dir && dn)) begin
          m_prev = k;
          m_wrap = m_dir ? (k == 0) : (k == 15);
        end else begin
          bump_err(); m_cnt = 0; m_lock = 0;
          if (n == 1) begin
            m_prev = k; m_state = 1;
          end else begin
            m_pv = 0; m_state = 0;
          end
        end
      end
    endcase
  endtask

  // Drive one sample (called at posedge+1), queue the prediction, compare
  // one clock later.
  task automatic step(input logic [15:0] v, input bit vld);
    exp_t e;
    led_in    = v;
    led_valid = vld;
    model(v, vld);
    e.pos = m_pos; e.pv = m_pv; e.dir = m_dir; e.lk = m_lock;
    e.er = m_err; e.wr = m_wrap; e.ec = m_ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pos",       32'(pos),        32'(e.pos));
    check("pos_valid", 32'(pos_valid),  32'(e.pv));
    check("dir",       32'(dir),        32'(e.dir));
    check("locked",    32'(locked),     32'(e.lk));
    check("err",       32'(err),        32'(e.er));
    check("wrap",      32'(wrap),       32'(e.wr));
    check("err_count", 32'(err_count),  32'(e.ec));
    check("err_count_w2", 32'(err_count2), 32'((e.ec > 3) ? 3 : e.ec));
    check("pos_w2",    32'(pos2),       32'(e.pos));
    check("locked_w2", 32'(locked2),    32'(e.lk));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pos"},       32'(pos),        0);
    check({tag, "_pos_valid"}, 32'(pos_valid),  0);
    check({tag, "_dir"},       32'(dir),        0);
    check({tag, "_locked"},    32'(locked),     0);
    check({tag, "_err"},       32'(err),        0);
    check({tag, "_wrap"},      32'(wrap),       0);
    check({tag, "_err_count"}, 32'(err_count),  0);
    check({tag, "_err_count_w2"}, 32'(err_count2), 0);
  endtask

  initial begin
    int          w;
    int          r;
    bit          up_dir;
    logic [15:0] v;

    reset     = 1'b0;
    led_in    = '0;
    led_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;

    // Ascending acquisition
    step(16'h0000, 1);
    step(16'h0001, 1);
    step(16'h0002, 1);
    step(16'h0004, 1);
    step(16'h0008, 1);
    check("acq_not_yet_locked", 32'(locked), 0);
    step(16'h0010, 1);
    check("asc_locked", 32'(locked), 1);
    check("asc_dir", 32'(dir), 1);
    check("asc_pos", 32'(pos), 4);
    check("asc_err_count", 32'(err_count), 0);

    step(16'h0020, 1);
    step(16'h0040, 1);
    step(16'h0080, 1);

    // Idle samples while locked: everything holds
    for (int i = 0; i < 10; i++) step(16'($urandom), 0);
    check("hold_pos", 32'(pos), 7);
    check("hold_locked", 32'(locked), 1);
    check("hold_dir", 32'(dir), 1);
    check("hold_pos_valid", 32'(pos_valid), 1);

    // Non-adjacent jump from 7 to 9 while locked
    step(16'h0200, 1);
    check("jump_err", 32'(err), 1);
    check("jump_locked", 32'(locked), 0);
    check("jump_pos", 32'(pos), 9);
    check("jump_pos_valid", 32'(pos_valid), 1);
    check("jump_err_count", 32'(err_count), 1);

    // Relock from 9 and cross the ascending wrap
    step(16'h0400, 1);
    step(16'h0800, 1);
    step(16'h1000, 1);
    step(16'h2000, 1);
    check("relock", 32'(locked), 1);
    step(16'h4000, 1);
    step(16'h8000, 1);
    step(16'h0001, 1);
    check("asc_wrap", 32'(wrap), 1);
    check("asc_wrap_pos", 32'(pos), 0);

    // BAD while locked
    step(16'h0041, 1);
    check("bad_err", 32'(err), 1);
    check("bad_pos_valid", 32'(pos_valid), 0);
    check("bad_err_count", 32'(err_count), 2);

    // Relock, then BLANK while locked
    step(16'h0002, 1);
    step(16'h0004, 1);
    step(16'h0008, 1);
    step(16'h0010, 1);
    step(16'h0020, 1);
    check("relock2", 32'(locked), 1);
    step(16'h0000, 1);
    check("blank_err", 32'(err), 1);
    check("blank_pos_valid", 32'(pos_valid), 0);
    check("blank_err_count", 32'(err_count), 3);

    // BAD in IDLE: narrow counter saturates
    step(16'h0003, 1);
    check("sat_err_count_w8", 32'(err_count), 4);
    check("sat_err_count_w2", 32'(err_count2), 3);

    // Descending acquisition across the wrap
    step(16'h0004, 1);
    step(16'h0002, 1);
    step(16'h0001, 1);
    step(16'h8000, 1);
    check("desc_acq_wrap_no_pulse", 32'(wrap), 0);
    step(16'h4000, 1);
    check("desc_locked", 32'(locked), 1);
    check("desc_dir", 32'(dir), 0);
    for (int k = 13; k >= 0; k--) step(16'(1) << k, 1);
    step(16'h8000, 1);
    check("desc_wrap1", 32'(wrap), 1);
    check("desc_wrap1_pos", 32'(pos), 15);
    check("desc_wrap1_dir", 32'(dir), 0);
    for (int k = 14; k >= 0; k--) step(16'(1) << k, 1);
    step(16'h8000, 1);
    check("desc_wrap2", 32'(wrap), 1);
    check("desc_wrap2_pos", 32'(pos), 15);

    // Reverse step while locked descending, then repeat of same position
    step(16'h0001, 1);
    check("reverse_err", 32'(err), 1);
    check("reverse_locked", 32'(locked), 0);
    step(16'h0001, 1);
    check("same_pos_no_err", 32'(err), 0);

    // Mid-walk asynchronous reset
    step(16'h0002, 1);
    step(16'h0004, 1);
    step(16'h0008, 1);
    #3;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    led_valid = 1'b0;
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // First valid sample after release is taken as in IDLE
    step(16'h0100, 1);
    check("post_reset_pos", 32'(pos), 8);
    check("post_reset_pos_valid", 32'(pos_valid), 1);
    check("post_reset_err", 32'(err), 0);

    // Mixed random traffic
    w      = 8;
    up_dir = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        w = (w + (up_dir ? 1 : 15)) % 16;
        step(16'(1) << w, 1);
      end else if (r < 63) begin
        w = (w + (up_dir ? 15 : 1)) % 16;
        step(16'(1) << w, 1);
      end else if (r < 70) begin
        w = $urandom_range(0, 15);
        step(16'(1) << w, 1);
      end else if (r < 77) begin
        step(16'h0000, 1);
      end else if (r < 82) begin
        v = 16'($urandom) | 16'h8001;
        step(v, 1);
      end else if (r < 87) begin
        up_dir = ~up_dir;
        step(16'(1) << w, 1);
      end else begin
        step(16'($urandom), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
